// File: rtl/fifo_stream_drain.sv
// ============================================================================
// Module   : fifo_stream_drain
// Purpose  : Drains a registered-output FIFO into a valid/ready stream with
//            per-packet last framing, using a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [CNT_W-1:0]      cnt;

  logic                  pop;
  logic [2:0]            level;

  assign pop = m_valid & m_ready;

  // Words already committed to the buffer after this cycle's pop; a new read
  // is only safe while that leaves a free slot for the returning word.
  assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rstn & ~fifo_empty & (level < 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_mem[head];
  assign m_last  = m_valid & (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      cnt        <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        buf_mem[tail] <= fifo_data;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        cnt  <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert ({1'b0, occ} + {2'b00, inflight} <= 3'd2);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
// Testbench for fifo_stream_drain: queue-based FIFO model, scoreboard of
// expected words and a decoupled output monitor.
`default_nettype none

module tb_fifo_stream_drain;

  localparam int DW  = 8;
  localparam int PKT = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO model: array with read/write indices, registered data_out
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_clr_en = 1'b0;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (rd_ptr == wr_ptr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial fifo_data = '0;

  always @(posedge clk) begin
    if (!rstn && fifo_clr_en) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) chk("read_of_empty_fifo", 32'd1, 32'd0);
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: stream-rule stability and scoreboard comparison on each beat
  int            beat_idx  = 0;
  int            acc_total = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (!rstn) begin
      beat_idx   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, m_valid}, 32'd1);
        chk("stall_data_held", {24'd0, m_data}, {24'd0, prev_data});
        chk("stall_last_held", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, m_data}, {24'd0, e});
          chk("beat_last", {31'd0, m_last}, {31'd0, ((beat_idx % PKT) == PKT - 1)});
        end
        beat_idx++;
        acc_total++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !m_valid && fifo_empty) && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, (n < budget)}, 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    int rd_cnt;
    int pushed;
    int n;
    int start;

    // Reset with data pending, then streaming
    rstn    = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data", {24'd0, m_data}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      tick();
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("first_rd_after_rst", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    chk("latency_n1_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_no_gap", {31'd0, m_valid}, 32'd1);
    end
    wait_drain(50, "stream_drain");

    // Back-pressure
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      if (i < 9) tick();
    end
    chk("bp_rd_pulses", rd_cnt, 2);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data", {24'd0, m_data}, 32'h01);
    tick();
    m_ready = 1'b1;
    wait_drain(50, "bp_drain");

    // Random ready and random arrivals
    pushed = 0;
    n      = 0;
    while ((pushed < 100 || exp_q.size() != 0) && n < 3000) begin
      m_ready = ($urandom_range(0, 1) == 1);
      if (pushed < 100 && $urandom_range(0, 1) == 1) begin
        push(DW'($urandom));
        pushed++;
      end
      tick();
      n++;
    end
    chk("rand_done", {31'd0, (n < 3000)}, 32'd1);
    m_ready = 1'b1;
    wait_drain(50, "rand_drain");

    // Trickle: one word every 3 cycles
    for (int w = 0; w < 8; w++) begin
      push(DW'(8'h40 + w));
      @(negedge clk);
      chk("trk_rd_en", {31'd0, fifo_rd_en}, 32'd1);
      chk("trk_valid_c0", {31'd0, m_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("trk_valid_c1", {31'd0, m_valid}, 32'd0);
      chk("trk_rd_c1", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      @(negedge clk);
      chk("trk_valid_c2", {31'd0, m_valid}, 32'd1);
      chk("trk_data_c2", {24'd0, m_data}, {24'd0, 8'h40 + 8'(w)});
      tick();
    end
    wait_drain(20, "trk_drain");

    // Reset mid-packet
    fifo_clr_en = 1'b1;
    start = acc_total;
    for (int i = 0; i < 6; i++) push(DW'(8'h10 + i));
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      #1;
      if (acc_total > start && (beat_idx % PKT) == 2) break;
      n++;
    end
    chk("mid_reached", {31'd0, (n < 50)}, 32'd1);
    tick();
    rstn = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'hA0 + i));
    start = acc_total;
    @(negedge clk);
    chk("mid_valid_after_rst", {31'd0, m_valid}, 32'd0);
    chk("mid_rd_after_rst", {31'd0, fifo_rd_en}, 32'd1);
    tick();
    wait_drain(50, "mid_drain");
    chk("mid_beats", acc_total - start, 4);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fifo_stream_drain.md
# fifo_stream_drain

Read-side drain for the synchronous FIFO. Pops words through the FIFO's `rd_en` / `empty` / registered `data_out` port and presents them as a valid/ready stream with per-packet `m_last` framing. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so downstream back-pressure never loses or duplicates a word, and throughput is one word per cycle.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `PKT_LEN`, default 4: beats per packet; `m_last` marks beat `PKT_LEN-1`; legal range ≥1.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_en`  out  1  FIFO read request.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  last beat of packet.

## Operation
- **State:**
  - 2-entry buffer `buf[0..1]` with head/tail pointers (1 bit each) and occupancy `occ` (0..2).
  - 1-bit `inflight` register.
  - Beat counter `cnt`, width `max(1,$clog2(PKT_LEN))`.
- **pop:** `pop = m_valid & m_ready`.
- **Read request:** `fifo_rd_en = rstn & !fifo_empty & ((occ + inflight - pop) < 2)`.
  - This is combinational from `fifo_empty` and `m_ready`. The path is accepted.
  - Because the request is gated by `!fifo_empty`, every assertion is a real FIFO pop.
- **inflight:** `inflight <= fifo_rd_en` each cycle.
- **Capture:** when `inflight == 1`, `fifo_data` is written to `buf[tail]` and tail advances.
- **Head:** on `pop`, head advances.
  - Capture and pop in the same cycle are both performed; `occ` is unchanged.
- **Outputs:**
  - `m_valid = (occ != 0)`.
  - `m_data = buf[head]`.
  - `m_last = m_valid & (cnt == PKT_LEN-1)`.
- **Beat counter:** on `pop`, `cnt` increments. It wraps to 0 after `PKT_LEN-1`. For `PKT_LEN == 1`, every beat is last.
- **Overflow invariant:** `occ + inflight ≤ 2` always. Any assertion failing this is a design error.
- **Stream rule:** while `m_valid & !m_ready`, `m_data` and `m_last` are held stable and `m_valid` stays high.
- **Reset** (`rstn` low at a posedge) clears:
  - `occ`, head, tail, `inflight` and `cnt` to 0;
  - buffer contents to 0.
  - A word in flight at reset is discarded. The FIFO shares `rstn` and clears too.
- **Reset values:**
  - `m_valid` = 0, `m_data` = 0, `m_last` = 0.
  - `fifo_rd_en` = 0 for as long as `rstn` is low.

## Timing
- `fifo_rd_en` rises in the same cycle `fifo_empty` falls, provided there is space.
- **Latency:**
  - `fifo_rd_en` high in cycle N.
  - `fifo_data` valid in cycle N+1, captured at the end of N+1.
  - `m_valid` high in cycle N+2.
  - First-word latency from `fifo_empty` falling is 2 cycles.
- **Steady state** with `m_ready = 1` and a non-empty FIFO: one read and one pop per cycle, so 100% throughput. `occ` = 1 and `inflight` = 1 in steady state.
- **`m_ready` low:** reads continue until `occ + inflight == 2`, then `fifo_rd_en` = 0.
  - On the cycle `m_ready` returns, `fifo_rd_en` may reassert.
  - No bubble in the output once the buffer is primed.
- **Empty FIFO:** no reads. The buffer drains normally. `m_valid` falls the cycle after the last pop of an empty buffer.
- **Packets:** `cnt` advances only on an accepted beat. Stalls and bubbles never shift packet boundaries.

## Test plan
- **Reset with data pending:**
  - Stimulus: `rstn` = 0 for 3 cycles with `fifo_empty` = 0 and `m_ready` = 1.
  - Required: `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0x00, `m_last` = 0 throughout. The first `fifo_rd_en` comes in the first cycle after `rstn` rises.
- **Streaming:**
  - Stimulus: FIFO model preloaded with 0x01..0x08, `m_ready` = 1, `PKT_LEN` = 4.
  - Required: `m_valid` rises 2 cycles after the first `fifo_rd_en`. 8 consecutive beats 0x01..0x08 with no gap. `m_last` high only on 0x04 and 0x08.
- **Back-pressure:**
  - Stimulus: FIFO holds 0x01..0x05, `m_ready` = 0 for 10 cycles, then 1.
  - Required: exactly 2 `fifo_rd_en` pulses during the stall. `m_data` held at 0x01. After release, the output is 0x01..0x05 in order with no loss or duplication.
- **Random ready:**
  - Stimulus: 100 words, `m_ready` random at 50%.
  - Required: output order equals input order. `m_last` on every 4th accepted beat. `occ + inflight ≤ 2` assertion never fires.
- **Trickle input:**
  - Stimulus: FIFO receives one word every 3 cycles, `m_ready` = 1.
  - Required: each word appears 2 cycles after its `fifo_rd_en`. `m_valid` is a 1-cycle pulse per word. Packet framing is correct across the bubbles.
- **Reset mid-packet:**
  - Stimulus: after 2 accepted beats of a packet, pulse `rstn` low for 1 cycle, then refill with 0xA0..0xA3.
  - Required: `m_valid` = 0 in the cycle after reset. Output is 0xA0..0xA3 with `m_last` on 0xA3 (counter restarted).
